truth_table_arbiter: RTL and testbench
======================================

// Module: truth_table_arbiter
// PURPOSE
// - Shares one truth_table_logic evaluator (p = a'bc | ab'c' | abc) among N_REQ requesters.
// - Round-robin arbitration; each requester hands over a 3-bit (a,b,c) vector with valid/ready.
// - Block registers the operand, evaluates it, and returns p tagged with the requester id
//   on one output channel that supports backpressure. Sits between the input-vector sources
//   and the result consumer.
// PARAMETERS
// - N_REQ  4   number of requesters (>=2)
// - CNT_W  16  width of the completed-evaluation counter
// - ID_W   (localparam) $clog2(N_REQ); requester id width
// PORTS
// - clk        in   1          single clock; all state updates on posedge
// - rst_n      in   1          synchronous, active-low reset
// - req_valid  in   N_REQ      bit i: requester i presents a vector
// - req_abc    in   3*N_REQ    vector i in bits [3i+2:3i], order {a,b,c}
// - req_ready  out  N_REQ      one-hot grant/accept; combinational, valid only in IDLE
// - res_valid  out  1          result register holds a result
// - res_ready  in   1          consumer accepts the result
// - res_p      out  1          evaluator output for the granted vector
// - res_id     out  ID_W       index of the requester that owns res_p
// - eval_cnt   out  CNT_W      number of completed result handshakes, saturating
// - busy       out  1          state != IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=N_REQ-1, res_valid=0, res_p=0, res_id=0,
//   eval_cnt=0, busy=0, operand reg=3'b000. req_ready=0 while rst_n=0.
// - FSM states: IDLE -> EVAL -> RESP -> IDLE.
//   IDLE: if |req_valid, assert req_ready[g] for granted g; latch req_abc[g] and g; go to EVAL.
//         If no request, stay in IDLE.
//   EVAL: evaluator sees the operand reg; at the end of the cycle, register p into res_p and
//         the id into res_id; set res_valid=1; go to RESP.
//   RESP: hold res_valid, res_p and res_id stable until res_valid&res_ready. On that handshake,
//         set res_valid=0, increment eval_cnt, and go to IDLE.
// - Latency: accept in cycle T -> res_valid=1 in cycle T+2. Peak throughput: 1 result per
//   3 cycles.
// - Arbitration: search starts at (rr_ptr+1) mod N_REQ and wraps. g = first i with
//   req_valid[i]=1. rr_ptr<=g only on accept. After reset, requester 0 has highest priority.
// - req_ready is at most one-hot. It is all-zero outside IDLE, so a request raised during
//   EVAL/RESP waits.
// - Requesters hold req_valid and req_abc stable until ready. Dropping valid before ready is
//   legal and causes no grant.
// - RESP handshake and a new req_valid in the same cycle: the request is not accepted that
//   cycle. It is accepted in the next IDLE cycle.
// - res_ready=1 outside RESP is ignored.
// - eval_cnt at all-ones stays at all-ones.
// - Reset mid-operation: the pending operand and the unconsumed result are discarded.
//   State returns to the reset values above on the next posedge.
// - X on req_abc for non-granted requesters has no effect.
// STRUCTURE
// - Shared package truth_table_pkg: state encoding localparams (IDLE=2'd0, EVAL=2'd1,
//   RESP=2'd2), default N_REQ/CNT_W.
// - Sub-module rr_grant_picker: req vector + pointer -> one-hot grant + encoded index.
//   Purely combinational.
// - Evaluator: instantiate the existing gate-level truth_table_logic unchanged, driven by the
//   operand reg.
// - FSM, operand reg, result reg and counter stay in this module.
// TESTING
// - Reset with rst_n=0 for 2 cycles, all req_valid=1 -> req_ready=0, res_valid=0,
//   eval_cnt=0, busy=0.
// - Single req: req_valid=4'b0100, req_abc[8:6]=3'b011, res_ready=1 -> req_ready=4'b0100 at
//   T; res_valid=1, res_p=1, res_id=2 at T+2; eval_cnt=1.
// - Sweep all 8 vectors from requester 0 -> res_p = 0,0,0,1,1,0,0,1 for abc=000..111.
// - Contention: req_valid=4'b1111 held, res_ready=1 -> grant order 0,1,2,3,0.
//   A grant every 3 cycles.
// - Backpressure: res_ready=0 for 5 cycles in RESP -> res_valid/res_p/res_id stable and
//   req_ready=0. Raising res_ready -> handshake, IDLE next cycle.
// - Reset asserted during EVAL with a pending abc=100 -> no result emitted, eval_cnt=0, and
//   the next grant goes to requester 0.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table arbiter slice: FSM state encoding,
// default sizing, and the round-robin search-order helper.
package truth_table_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Position visited at step k of a search that starts just after ptr.
  function automatic int rr_index(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/truth_table_arbiter_if.sv
// Request and result channels of the truth-table arbiter. The arbiter is the
// slave; requesters and the result consumer together form the master side.
interface truth_table_arbiter_if #(
  parameter int N_REQ = truth_table_pkg::DEF_N_REQ
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [3*N_REQ-1:0] req_abc;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid;
  logic               res_ready;
  logic               res_p;
  logic [ID_W-1:0]    res_id;

  modport master (
    output req_valid, req_abc, res_ready,
    input  req_ready, res_valid, res_p, res_id
  );

  modport slave (
    input  req_valid, req_abc, res_ready,
    output req_ready, res_valid, res_p, res_id
  );

endinterface

// File: rtl/truth_table_arbiter_rr_grant_picker.sv
// Combinational round-robin picker: first requester after the pointer wins,
// reported both one-hot and encoded.
module rr_grant_picker
  import truth_table_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  logic [ID_W-1:0] w_pos;
  logic            w_hit;

  // Walk pointer+1 .. pointer+N_REQ; only the first set bit may hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos          = ID_W'(rr_index(int'(i_ptr), k, N_REQ));
      w_hit          = i_req[w_pos] & ~o_any;
      o_grant[w_pos] = w_hit;
      o_idx          = w_hit ? w_pos : o_idx;
      o_any          = o_any | w_hit;
    end
  end

endmodule

// File: rtl/truth_table_logic.sv
// Gate-level evaluator: p = a'bc | ab'c' | abc.
module truth_table_logic (
  input  wire a,
  input  wire b,
  input  wire c,
  output wire p
);

  wire w_na;
  wire w_nb;
  wire w_nc;
  wire w_t0;
  wire w_t1;
  wire w_t2;

  not u_na (w_na, a);
  not u_nb (w_nb, b);
  not u_nc (w_nc, c);
  and u_t0 (w_t0, w_na, b, c);
  and u_t1 (w_t1, a, w_nb, w_nc);
  and u_t2 (w_t2, a, b, c);
  or  u_p  (p, w_t0, w_t1, w_t2);

endmodule

// File: rtl/truth_table_arbiter.sv
// Shares one truth_table_logic evaluator among N_REQ requesters with
// round-robin arbitration and a single backpressured result channel.
module truth_table_arbiter
  import truth_table_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_arbiter_if.slave bus,
  output logic [CNT_W-1:0]     eval_cnt,
  output logic                 busy
);

  localparam int ID_W = $clog2(N_REQ);

  state_t            r_state;
  state_t            w_next_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [2:0]        r_operand;
  logic [ID_W-1:0]   r_op_id;
  logic              r_res_valid;
  logic              r_res_p;
  logic [ID_W-1:0]   r_res_id;
  logic [CNT_W-1:0]  r_eval_cnt;

  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic [2:0]        w_abc_sel;
  logic              w_p;
  logic              w_accept;
  logic              w_load_res;
  logic              w_res_hs;

  rr_grant_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  truth_table_logic u_eval (
    .a (r_operand[2]),
    .b (r_operand[1]),
    .c (r_operand[0]),
    .p (w_p)
  );

  // AND-OR mux keeps unknowns on non-granted lanes out of the operand.
  always_comb begin
    w_abc_sel = 3'b000;
    for (int i = 0; i < N_REQ; i++) begin
      w_abc_sel = w_abc_sel | ({3{w_grant[i]}} & bus.req_abc[3*i +: 3]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: w_next_state = w_any ? ST_EVAL : ST_IDLE;
      ST_EVAL: w_next_state = ST_RESP;
      ST_RESP: w_next_state = w_res_hs ? ST_IDLE : ST_RESP;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs; grants are suppressed while reset is held.
  always_comb begin
    bus.req_ready = '0;
    w_accept      = 1'b0;
    w_load_res    = 1'b0;
    w_res_hs      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = rst_n ? w_grant : '0;
        w_accept      = rst_n & w_any;
      end
      ST_EVAL: w_load_res = 1'b1;
      ST_RESP: w_res_hs   = r_res_valid & bus.res_ready;
      default: w_accept   = 1'b0;
    endcase
  end

  // Operand, pointer, result and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= ID_W'(N_REQ - 1);
      r_operand   <= 3'b000;
      r_op_id     <= '0;
      r_res_valid <= 1'b0;
      r_res_p     <= 1'b0;
      r_res_id    <= '0;
      r_eval_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_operand <= w_abc_sel;
        r_op_id   <= w_idx;
        r_rr_ptr  <= w_idx;
      end
      if (w_load_res) begin
        r_res_p     <= w_p;
        r_res_id    <= r_op_id;
        r_res_valid <= 1'b1;
      end
      if (w_res_hs) begin
        r_res_valid <= 1'b0;
        if (r_eval_cnt != {CNT_W{1'b1}}) begin
          r_eval_cnt <= r_eval_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_p     = r_res_p;
  assign bus.res_id    = r_res_id;
  assign eval_cnt      = r_eval_cnt;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_truth_table_arbiter.sv
// Directed bench for truth_table_arbiter: reset, single request, full
// evaluator sweep, backpressure, reset during evaluation, contention.
module tb_truth_table_arbiter;

  localparam int N_REQ = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] eval_cnt;
  logic             busy;

  int n_assert;
  int n_fail;

  truth_table_arbiter_if #(.N_REQ(N_REQ)) bif ();

  truth_table_arbiter #(
    .N_REQ (N_REQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif.slave),
    .eval_cnt (eval_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_p_tab;
    logic [3:0] exp_grant [0:4];
    logic       exp_cont_p [0:4];
    int         exp_id [0:4];
    n_assert = 0;
    n_fail   = 0;

    // Reset held two cycles with every requester asking.
    rst_n         = 1'b0;
    bif.req_valid = 4'b1111;
    bif.req_abc   = 12'h000;
    bif.res_ready = 1'b0;
    tick();
    chk("rst_req_ready", 32'(bif.req_ready), 32'h0);
    tick();
    chk("rst_req_ready2", 32'(bif.req_ready), 32'h0);
    chk("rst_res_valid", 32'(bif.res_valid), 32'h0);
    chk("rst_eval_cnt", 32'(eval_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    bif.req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();

    // Single request from requester 2 with abc=011 -> p=1.
    bif.req_valid   = 4'b0100;
    bif.req_abc     = 12'h000;
    bif.req_abc[8:6] = 3'b011;
    bif.res_ready   = 1'b1;
    #1;
    chk("single_ready", 32'(bif.req_ready), 32'h4);
    tick();
    bif.req_valid = 4'b0000;
    chk("single_busy_eval", 32'(busy), 32'h1);
    chk("single_noval_t1", 32'(bif.res_valid), 32'h0);
    tick();
    chk("single_res_valid", 32'(bif.res_valid), 32'h1);
    chk("single_res_p", 32'(bif.res_p), 32'h1);
    chk("single_res_id", 32'(bif.res_id), 32'h2);
    tick();
    chk("single_res_cleared", 32'(bif.res_valid), 32'h0);
    chk("single_eval_cnt", 32'(eval_cnt), 32'h1);
    chk("single_idle", 32'(busy), 32'h0);

    // Sweep all eight vectors from requester 0: p = 0,0,0,1,1,0,0,1.
    exp_p_tab = 8'b1001_1000;
    for (int v = 0; v < 8; v++) begin
      bif.req_valid    = 4'b0001;
      bif.req_abc[2:0] = 3'(v);
      #1;
      chk($sformatf("sweep%0d_ready", v), 32'(bif.req_ready), 32'h1);
      tick();
      bif.req_valid = 4'b0000;
      tick();
      chk($sformatf("sweep%0d_p", v), 32'(bif.res_p), 32'(exp_p_tab[v]));
      chk($sformatf("sweep%0d_id", v), 32'(bif.res_id), 32'h0);
      tick();
    end
    chk("sweep_eval_cnt", 32'(eval_cnt), 32'd9);

    // Backpressure: requester 3 with abc=111, consumer stalls 5 cycles.
    bif.req_abc      = 12'h000;
    bif.req_abc[11:9] = 3'b111;
    bif.req_abc[2:0] = 3'b100;
    bif.res_ready    = 1'b0;
    bif.req_valid    = 4'b1000;
    #1;
    chk("bp_ready", 32'(bif.req_ready), 32'h8);
    tick();
    bif.req_valid = 4'b0001;
    chk("bp_eval_ready0", 32'(bif.req_ready), 32'h0);
    tick();
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("bp%0d_valid", s), 32'(bif.res_valid), 32'h1);
      chk($sformatf("bp%0d_p", s), 32'(bif.res_p), 32'h1);
      chk($sformatf("bp%0d_id", s), 32'(bif.res_id), 32'h3);
      chk($sformatf("bp%0d_ready0", s), 32'(bif.req_ready), 32'h0);
      tick();
    end
    bif.res_ready = 1'b1;
    #1;
    chk("bp_hs_ready0", 32'(bif.req_ready), 32'h0);
    tick();
    chk("bp_after_valid", 32'(bif.res_valid), 32'h0);
    chk("bp_after_idle", 32'(busy), 32'h0);
    chk("bp_eval_cnt", 32'(eval_cnt), 32'd10);
    chk("bp_next_grant", 32'(bif.req_ready), 32'h1);

    // Reset while requester 0's abc=100 sits in the operand register.
    tick();
    chk("rstmid_busy", 32'(busy), 32'h1);
    rst_n         = 1'b0;
    bif.req_valid = 4'b0000;
    tick();
    chk("rstmid_valid", 32'(bif.res_valid), 32'h0);
    chk("rstmid_cnt", 32'(eval_cnt), 32'h0);
    chk("rstmid_busy0", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_no_result", 32'(bif.res_valid), 32'h0);

    // Contention: all requesters held, grant order 0,1,2,3,0 every 3 cycles.
    bif.req_abc[2:0]  = 3'b100;
    bif.req_abc[5:3]  = 3'b000;
    bif.req_abc[8:6]  = 3'b011;
    bif.req_abc[11:9] = 3'b110;
    bif.req_valid     = 4'b1111;
    bif.res_ready     = 1'b1;
    exp_grant[0] = 4'b0001; exp_id[0] = 0; exp_cont_p[0] = 1'b1;
    exp_grant[1] = 4'b0010; exp_id[1] = 1; exp_cont_p[1] = 1'b0;
    exp_grant[2] = 4'b0100; exp_id[2] = 2; exp_cont_p[2] = 1'b1;
    exp_grant[3] = 4'b1000; exp_id[3] = 3; exp_cont_p[3] = 1'b0;
    exp_grant[4] = 4'b0001; exp_id[4] = 0; exp_cont_p[4] = 1'b1;
    #1;
    for (int k = 0; k < 15; k++) begin
      if (k % 3 == 0) begin
        chk($sformatf("cont%0d_grant", k), 32'(bif.req_ready), 32'(exp_grant[k/3]));
      end else begin
        chk($sformatf("cont%0d_nogrant", k), 32'(bif.req_ready), 32'h0);
      end
      if (k % 3 == 2) begin
        chk($sformatf("cont%0d_valid", k), 32'(bif.res_valid), 32'h1);
        chk($sformatf("cont%0d_id", k), 32'(bif.res_id), 32'(exp_id[k/3]));
        chk($sformatf("cont%0d_p", k), 32'(bif.res_p), 32'(exp_cont_p[k/3]));
      end
      tick();
    end
    bif.req_valid = 4'b0000;
    chk("cont_eval_cnt", 32'(eval_cnt), 32'd5);
    tick();
    chk("cont_final_idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
